// File: rtl/data_mem_sync_pkg.sv
// data_mem_sync_pkg: shared state encoding and elaboration helpers for the synchronous data memory
`ifndef DATA_MEM_LANES
`define DATA_MEM_LANES(w) ((w) / 8)
`endif

package data_mem_sync_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lanes(input int w);
        return `DATA_MEM_LANES(w);
    endfunction

    function automatic bit data_w_ok(input int w);
        return (w > 0) && ((w % 8) == 0);
    endfunction

endpackage

// File: rtl/data_mem_sync_if.sv
// data_mem_sync_if: request/response bus between the load/store unit and the data memory
interface data_mem_sync_if
    import data_mem_sync_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic [lanes(DATA_W)-1:0]   req_be;
    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic                       init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

endinterface

// File: rtl/data_mem_sync_array.sv
// data_mem_sync_array: DEPTH x DATA_W storage with one byte-enabled write port and one registered read port
module data_mem_sync_array
    import data_mem_sync_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [lanes(DATA_W)-1:0]   i_be,
    input  logic                       i_re,
    input  logic [AW-1:0]              i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);
    localparam int LANES = lanes(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Update enabled byte lanes; the read register only moves on a read so it holds the last returned word
    always_ff @(posedge clk) begin
        if (i_we)
            for (int i = 0; i < LANES; i++)
                if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: clocked data memory with valid/ready requests, byte enables, range errors and post-reset clear
module data_mem_sync
    import data_mem_sync_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int OUT_REG = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_sync_if.slave bus
);
    localparam int AW    = clog2(DEPTH);
    localparam int LANES = lanes(DATA_W);

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("data_mem_sync: DATA_W must be a positive multiple of 8");
    end

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_clr_ptr;
    logic                w_init;
    logic                w_ready;
    logic                w_accept;
    logic                w_in_range;
    logic                w_we;
    logic                w_re;
    logic [AW-1:0]       w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [LANES-1:0]    w_be;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic [DATA_W-1:0]   w_rdata1;
    logic                r_v1;
    logic                r_err1;
    logic                r_rd1;

    // State register: every reset restarts the clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_next;
    end

    // Next state: leave INIT once the last word has been cleared
    always_comb begin
        w_next = (r_state == ST_INIT && r_clr_ptr == AW'(DEPTH - 1)) ? ST_READY : r_state;
    end

    // State decode: requests are only taken once the clear sweep is over
    always_comb begin
        w_init  = (r_state == ST_INIT);
        w_ready = (r_state == ST_READY);
    end

    // Clear pointer walks the array once per INIT visit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_clr_ptr <= '0;
        else if (w_init) r_clr_ptr <= r_clr_ptr + AW'(1);
    end

    // Full-width compare so out-of-range upper address bits never alias onto real words
    assign w_in_range = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_accept   = bus.req_valid & w_ready;

    // The clear sweep owns the write port during INIT; requests own it afterwards
    assign w_we    = w_init | (w_accept & bus.req_we & w_in_range);
    assign w_re    = w_accept & ~bus.req_we & w_in_range;
    assign w_waddr = w_init ? r_clr_ptr : bus.req_addr[AW-1:0];
    assign w_wdata = w_init ? '0 : bus.req_wdata;
    assign w_be    = w_init ? '1 : bus.req_be;

    data_mem_sync_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_be    (w_be),
        .i_re    (w_re),
        .i_raddr (bus.req_addr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // First response stage: flags captured only on accept so they hold between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_err1 <= 1'b0;
            r_rd1  <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_err1 <= ~w_in_range;
                r_rd1  <= ~bus.req_we & w_in_range;
            end
        end
    end

    // Writes and errored reads return zero; good reads return the array word
    assign w_rdata1 = r_rd1 ? w_mem_rdata : '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic              r_v2;
        logic              r_err2;
        logic [DATA_W-1:0] r_rdata2;

        // Optional output register adds one cycle of latency and keeps the last response stable
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2     <= 1'b0;
                r_err2   <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_err2   <= r_err1;
                    r_rdata2 <= w_rdata1;
                end
            end
        end

        assign bus.rsp_valid = r_v2;
        assign bus.rsp_err   = r_err2;
        assign bus.rsp_rdata = r_rdata2;
    end else begin : g_no_out_reg
        assign bus.rsp_valid = r_v1;
        assign bus.rsp_err   = r_err1;
        assign bus.rsp_rdata = w_rdata1;
    end

    assign bus.req_ready = w_ready;
    assign bus.init_done = w_ready;

endmodule
